// File: rtl/e4m3_stream_accumulator.sv
// E4M3 packet accumulator: sums a valid/ready stream of FP8 values
// per packet using a multi-cycle align/add/normalize/pack FSM.
module e4m3_stream_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_PACK  = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [7:0]        acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        x_q, x_d;
    logic              last_q, last_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [7:0]        sig_a_q, sig_a_d;
    logic [7:0]        sig_b_q, sig_b_d;
    logic [7:0]        sum_q, sum_d;
    logic signed [5:0] exp_q, exp_d;

    // Operand decode: significand is {1, fff, 3 guard bits, sticky}
    logic [7:0]  xv;
    logic [3:0]  a_e, x_e, big_e, small_e, dsh;
    logic [6:0]  a_mag, x_mag;
    logic [7:0]  a_sig, x_sig, big_sig, small_sig, sh_sig;
    logic [15:0] sh_full;
    logic        a_big;
    logic [8:0]  add9;
    logic [7:0]  sub8;

    // Alignment and add datapath feeding the FSM registers
    always_comb begin
        xv        = (x_q[6:0] == 7'h7F) ? {x_q[7], 7'h7E} : x_q;
        a_e       = acc_q[6:3];
        x_e       = xv[6:3];
        a_mag     = (a_e == 4'd0) ? 7'd0 : acc_q[6:0];
        x_mag     = (x_e == 4'd0) ? 7'd0 : xv[6:0];
        a_sig     = (a_e == 4'd0) ? 8'd0 : {1'b1, acc_q[2:0], 4'd0};
        x_sig     = (x_e == 4'd0) ? 8'd0 : {1'b1, xv[2:0], 4'd0};
        a_big     = (a_mag >= x_mag);
        big_e     = a_big ? a_e : x_e;
        small_e   = a_big ? x_e : a_e;
        big_sig   = a_big ? a_sig : x_sig;
        small_sig = a_big ? x_sig : a_sig;
        dsh       = big_e - small_e;
        sh_full   = {small_sig, 8'd0} >> dsh;
        if (dsh >= 4'd7) begin
            sh_sig = {7'd0, |small_sig};
        end else begin
            sh_sig = {sh_full[15:9], sh_full[8] | (|sh_full[7:0])};
        end
        add9 = {1'b0, sig_a_q} + {1'b0, sig_b_q};
        sub8 = sig_a_q - sig_b_q;
    end

    // Next-state and datapath register logic
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        x_d      = x_q;
        last_d   = last_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        sig_a_d  = sig_a_q;
        sig_b_d  = sig_b_q;
        sum_d    = sum_q;
        exp_d    = exp_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = in_data;
                    last_d  = in_last;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                sign_a_d = a_big ? acc_q[7] : xv[7];
                sign_b_d = a_big ? xv[7] : acc_q[7];
                sig_a_d  = big_sig;
                sig_b_d  = sh_sig;
                exp_d    = $signed({2'b00, big_e});
                state_d  = S_ADD;
            end
            S_ADD: begin
                if (sign_a_q == sign_b_q) begin
                    if (add9[8]) begin
                        sum_d = {add9[8:2], add9[1] | add9[0]};
                        exp_d = exp_q + 6'sd1;
                    end else begin
                        sum_d = add9[7:0];
                    end
                end else begin
                    sum_d = sub8;
                end
                state_d = (sum_d == 8'd0 || sum_d[7]) ? S_PACK : S_NORM;
            end
            S_NORM: begin
                sum_d   = {sum_q[6:0], 1'b0};
                exp_d   = exp_q - 6'sd1;
                state_d = sum_d[7] ? S_PACK : S_NORM;
            end
            S_PACK: begin
                if (sum_q == 8'd0) begin
                    acc_d = 8'h00;
                end else if (exp_q > 6'sd15 ||
                             (exp_q == 6'sd15 && sum_q[6:4] == 3'b111)) begin
                    acc_d = {sign_a_q, 7'h7E};
                    ovf_d = 1'b1;
                end else if (exp_q < 6'sd1) begin
                    acc_d = 8'h00;
                end else begin
                    acc_d = {sign_a_q, exp_q[3:0], sum_q[6:4]};
                end
                state_d = last_q ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                if (out_ready) begin
                    acc_d   = 8'h00;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= 8'h00;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            x_q      <= 8'h00;
            last_q   <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            sig_a_q  <= 8'h00;
            sig_b_q  <= 8'h00;
            sum_q    <= 8'h00;
            exp_q    <= 6'sd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            x_q      <= x_d;
            last_q   <= last_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            sig_a_q  <= sig_a_d;
            sig_b_q  <= sig_b_d;
            sum_q    <= sum_d;
            exp_q    <= exp_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_e4m3_stream_accumulator.sv
// Self-checking bench for e4m3_stream_accumulator: table of packets,
// scoreboard queue, and hand-written hold / wrap / reset sequences.
module tb_e4m3_stream_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_last;
    logic [7:0] in_data;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic [7:0] out_count;
    logic       out_ovf;

    e4m3_stream_accumulator #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count),
        .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          n;
        logic [31:0] d;
        logic [7:0]  data;
        logic [7:0]  cnt;
        logic        ovf;
        int          lat;
    } pkt_t;

    typedef struct {
        logic [7:0] data;
        logic [7:0] cnt;
        logic       ovf;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_cyc = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int   lat = 0;
        exp_t e;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_data"}, 32'(out_data), 32'(e.data));
        check({name, "_count"}, 32'(out_count), 32'(e.cnt));
        check({name, "_ovf"}, 32'(out_ovf), 32'(e.ovf));
        check({name, "_lat"}, 32'(lat), 32'(e.lat));
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_valid_fall"}, 32'(out_valid), 32'd0);
        check({name, "_ready_rise"}, 32'(in_ready), 32'd1);
    endtask

    pkt_t tbl[8];

    initial begin
        int first_cyc;
        tbl[0] = '{2, 32'h0000_3838, 8'h40, 8'd2, 1'b0, 3};
        tbl[1] = '{2, 32'h0000_BC44, 8'h3C, 8'd2, 1'b0, 4};
        tbl[2] = '{2, 32'h0000_B838, 8'h00, 8'd2, 1'b0, 3};
        tbl[3] = '{2, 32'h0000_8840, 8'h3F, 8'd2, 1'b0, 4};
        tbl[4] = '{1, 32'h0000_007F, 8'h7E, 8'd1, 1'b0, 3};
        tbl[5] = '{1, 32'h0000_0005, 8'h00, 8'd1, 1'b0, 3};
        tbl[6] = '{2, 32'h0000_8908, 8'h00, 8'd2, 1'b0, 6};
        tbl[7] = '{2, 32'h0000_C8C8, 8'hD0, 8'd2, 1'b0, 3};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < tbl[p].n; i++) begin
                if (i == tbl[p].n - 1)
                    sb.push_back('{tbl[p].data, tbl[p].cnt,
                                   tbl[p].ovf, tbl[p].lat});
                send(tbl[p].d[8*i +: 8], i == tbl[p].n - 1);
            end
            wait_out($sformatf("pkt%0d", p));
            handshake($sformatf("pkt%0d", p));
        end

        // Saturation, then RZ of 448-1; hold output with in_valid asserted
        send(8'h7E, 1'b0);
        send(8'h7E, 1'b0);
        sb.push_back('{8'h7D, 8'd3, 1'b1, 3});
        send(8'hB8, 1'b1);
        wait_out("sat");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h38;
            in_last  = 1'b1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'h7D);
            check("hold_count", 32'(out_count), 32'd3);
            check("hold_ovf", 32'(out_ovf), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        handshake("sat");

        // Counter wrap: 257 elements, element spacing of 4 cycles
        send(8'h00, 1'b0);
        first_cyc = acc_cyc;
        send(8'h00, 1'b0);
        check("b2b_gap", 32'(acc_cyc - first_cyc), 32'd4);
        for (int i = 2; i < 256; i++) send(8'h00, 1'b0);
        sb.push_back('{8'h38, 8'd1, 1'b0, 3});
        send(8'h38, 1'b1);
        wait_out("wrap");
        handshake("wrap");

        // Reset in the middle of normalization of a 3-element packet
        send(8'h40, 1'b0);
        send(8'h44, 1'b0);
        send(8'hC8, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_count", 32'(out_count), 32'd0);
        check("arst_out_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{8'h30, 8'd1, 1'b0, 3});
        send(8'h30, 1'b1);
        wait_out("post_rst");
        handshake("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
